// File: rtl/irq_edge_pkg.sv
// Shared CSR offsets and field widths for the edge-detect interrupt block.
package irq_edge_pkg;
    localparam int DEB_W = 4;

    localparam logic [4:0] OFF_RISE  = 5'd0;
    localparam logic [4:0] OFF_FALL  = 5'd1;
    localparam logic [4:0] OFF_DEB   = 5'd2;
    localparam logic [4:0] OFF_STATE = 5'd3;
endpackage

// File: rtl/irq_edge_line.sv
// One input line: 2-flop synchronizer, tick-based debounce and edge pulse.
module irq_edge_line
    import irq_edge_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             line_in,
    input  logic             tick,
    input  logic [DEB_W-1:0] deb_n,
    input  logic             clear,
    input  logic             prime,
    input  logic             rise_en,
    input  logic             fall_en,
    output logic             stable_o,
    output logic             irq_o
);
    logic             s1_q, s2_q, stable_q, irq_q;
    logic             s1_d, s2_d, stable_d, irq_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d     = line_in;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (prime || deb_n == '0) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else if (s2_q == stable_q || clear) begin
            // A DEB write restarts the count even if this cycle also ticks.
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == deb_n - 1'b1) begin
                stable_d = s2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        irq_d = !prime && (stable_d != stable_q) && (stable_d ? rise_en : fall_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
        end
    end

    assign stable_o = stable_q;
    assign irq_o    = irq_q;
endmodule

// File: rtl/irq_edge.sv
// Edge-triggered interrupt source: CSR block, debounce prescaler and
// post-reset priming shared by NUM_LINES per-line detectors.
module irq_edge
    import irq_edge_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR = 5'h0,
    parameter int         NUM_LINES = 8,
    parameter int         TICK_DIV  = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           csr_a,
    input  logic [7:0]           csr_di,
    input  logic                 csr_we,
    output logic [7:0]           csr_do,
    input  logic [NUM_LINES-1:0] lines_in,
    output logic [NUM_LINES-1:0] irqs_out
);
    localparam int DIV_W = $clog2(TICK_DIV);

    logic [NUM_LINES-1:0] rise_q, rise_d, fall_q, fall_d, stable;
    logic [DEB_W-1:0]     deb_q, deb_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [1:0]           prime_q, prime_d;
    logic [4:0]           off;
    logic                 tick, prime, clear;

    assign off   = csr_a - BASE_ADDR;
    assign tick  = (div_q == DIV_W'(TICK_DIV - 1));
    assign prime = (prime_q != 2'd3);
    assign clear = csr_we && (off == OFF_DEB);

    always_comb begin
        rise_d  = rise_q;
        fall_d  = fall_q;
        deb_d   = deb_q;
        div_d   = tick ? '0 : div_q + 1'b1;
        prime_d = prime ? prime_q + 2'd1 : prime_q;
        if (csr_we) begin
            case (off)
                OFF_RISE: rise_d = csr_di[NUM_LINES-1:0];
                OFF_FALL: fall_d = csr_di[NUM_LINES-1:0];
                OFF_DEB:  deb_d  = csr_di[DEB_W-1:0];
                default:  ;
            endcase
        end
    end

    always_comb begin
        csr_do = '0;
        case (off)
            OFF_RISE:  csr_do[NUM_LINES-1:0] = rise_q;
            OFF_FALL:  csr_do[NUM_LINES-1:0] = fall_q;
            OFF_DEB:   csr_do[DEB_W-1:0]     = deb_q;
            OFF_STATE: csr_do[NUM_LINES-1:0] = stable;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q  <= '0;
            fall_q  <= '0;
            deb_q   <= '0;
            div_q   <= '0;
            prime_q <= '0;
        end else begin
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            deb_q   <= deb_d;
            div_q   <= div_d;
            prime_q <= prime_d;
        end
    end

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        irq_edge_line u_line (
            .clk      (clk),
            .rst_n    (rst_n),
            .line_in  (lines_in[i]),
            .tick     (tick),
            .deb_n    (deb_q),
            .clear    (clear),
            .prime    (prime),
            .rise_en  (rise_q[i]),
            .fall_en  (fall_q[i]),
            .stable_o (stable[i]),
            .irq_o    (irqs_out[i])
        );
    end
endmodule

// File: tb/tb_irq_edge.sv
// Randomized + directed bench for irq_edge with a scoreboard of expected pulses.
module tb_irq_edge;
    localparam logic [4:0] BASE = 5'h04;
    localparam int         T    = 4;

    logic       clk = 1'b0, rst_n = 1'b0, csr_we = 1'b0;
    logic [4:0] csr_a = '0;
    logic [7:0] csr_di = '0, csr_do, lines_in = '0, irqs_out;

    always #5 clk = ~clk;

    irq_edge #(.BASE_ADDR(BASE), .NUM_LINES(8), .TICK_DIV(T)) dut (
        .clk(clk), .rst_n(rst_n), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
        .csr_do(csr_do), .lines_in(lines_in), .irqs_out(irqs_out)
    );

    int n_chk = 0, n_fail = 0;
    task automatic check(string name, logic [7:0] got, logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: level sampled two edges ago, ticks at every edge number
    // divisible by T, acceptance once N ticks fall inside an unbroken mismatch run.
    typedef struct { int unsigned e; logic [7:0] m; } exp_t;
    exp_t        sb[$];
    logic [7:0]  smp[$];
    int unsigned E = 0;
    logic [7:0]  m_rise, m_fall, m_stable, m_s2, m_pulse;
    logic [3:0]  m_deb;
    logic [4:0]  m_off;
    logic        m_clr, m_ns;
    bit          run[8];
    int unsigned rs[8];

    always @(posedge clk) begin
        if (!rst_n) begin
            E = 0;
            smp = '{8'h00, 8'h00};
            m_rise = '0; m_fall = '0; m_deb = '0; m_stable = '0;
            for (int i = 0; i < 8; i++) run[i] = 0;
        end else begin
            E++;
            m_s2 = smp.pop_front();
            smp.push_back(lines_in);
            m_off   = csr_a - BASE;
            m_clr   = csr_we && m_off == 5'd2;
            m_pulse = '0;
            for (int i = 0; i < 8; i++) begin
                m_ns = m_stable[i];
                if (E <= 3 || m_deb == 0) begin
                    m_ns = m_s2[i];
                    run[i] = 0;
                end else if (m_s2[i] == m_stable[i]) begin
                    run[i] = 0;
                end else begin
                    if (!run[i]) begin run[i] = 1; rs[i] = E; end
                    if (m_clr) rs[i] = E + 1;
                    else if (E % T == 0 && (E / T - (rs[i] - 1) / T) == m_deb) m_ns = m_s2[i];
                end
                if (m_ns != m_stable[i]) begin
                    run[i] = 0;
                    if (E > 3 && (m_ns ? m_rise[i] : m_fall[i])) m_pulse[i] = 1'b1;
                end
                m_stable[i] = m_ns;
            end
            if (m_pulse != 0) sb.push_back('{E, m_pulse});
            if (csr_we) begin
                case (m_off)
                    5'd0: m_rise = csr_di;
                    5'd1: m_fall = csr_di;
                    5'd2: m_deb  = csr_di[3:0];
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [7:0] exp_rd(logic [4:0] a);
        logic [4:0] o;
        o = a - BASE;
        case (o)
            5'd0: return m_rise;
            5'd1: return m_fall;
            5'd2: return {4'h0, m_deb};
            5'd3: return m_stable;
            default: return 8'h00;
        endcase
    endfunction

    // Monitor: every cycle the output must equal the queued pulse for this edge, or zero.
    logic [7:0] mon_exp;
    int         pcnt[8];
    always @(negedge clk) begin
        if (!rst_n) begin
            check("irq_in_reset", irqs_out, 8'h00);
        end else if (E > 0) begin
            mon_exp = 8'h00;
            if (sb.size() > 0 && sb[0].e == E) begin
                mon_exp = sb[0].m;
                sb.delete(0);
            end
            check("irq", irqs_out, mon_exp);
            for (int i = 0; i < 8; i++) if (irqs_out[i]) pcnt[i]++;
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(logic [4:0] off, logic [7:0] d);
        @(negedge clk);
        csr_a = BASE + off; csr_di = d; csr_we = 1'b1;
        @(negedge clk);
        csr_we = 1'b0;
    endtask

    task automatic rdc(string name, logic [4:0] a, logic [7:0] exp);
        @(negedge clk);
        csr_a = a;
        #1 check(name, csr_do, exp);
    endtask

    task automatic rdm(string name, logic [4:0] a);
        @(negedge clk);
        csr_a = a;
        #1 check(name, csr_do, exp_rd(a));
    endtask

    // Release reset at a negedge and program RISE/FALL=FF inside the priming window.
    task automatic release_en();
        rst_n = 1'b1;
        csr_a = BASE; csr_di = 8'hFF; csr_we = 1'b1;
        @(negedge clk);
        csr_a = BASE + 5'd1;
        @(negedge clk);
        csr_we = 1'b0;
    endtask

    task automatic async_reset(string name);
        #2 rst_n = 1'b0;
        sb.delete();
        #1 check(name, irqs_out, 8'h00);
        cyc(3);
    endtask

    int p0, p1, p2, p3;

    initial begin
        lines_in = 8'hFF;
        rdc("rst_rise", BASE, 8'h00);
        rdc("rst_deb", BASE + 5'd2, 8'h00);
        check("rst_irq", irqs_out, 8'h00);
        @(negedge clk);
        release_en();
        cyc(1);
        rdc("state_ff", BASE + 5'd3, 8'hFF);
        rdc("rise_ff", BASE, 8'hFF);

        // N=0 latency and no pulse on the disabled falling edge
        wr(5'd1, 8'h00); wr(5'd0, 8'h01);
        lines_in = 8'h00;
        cyc(6);
        p0 = pcnt[0];
        lines_in = 8'h01;
        @(negedge clk); check("lat_e1", irqs_out, 8'h00);
        @(negedge clk); check("lat_e2", irqs_out, 8'h00);
        @(negedge clk); check("lat_e3", irqs_out, 8'h01);
        @(negedge clk); check("lat_e4", irqs_out, 8'h00);
        lines_in = 8'h00;
        cyc(6);
        check("n0_one_pulse", 8'(pcnt[0] - p0), 8'd1);

        // N=3 debounce: 2-tick glitch rejected, 3+ ticks accepted
        wr(5'd1, 8'h02); wr(5'd0, 8'h00); wr(5'd2, 8'h03);
        lines_in = 8'h02;
        cyc(24);
        rdc("deb_state_hi", BASE + 5'd3, 8'h02);
        p1 = pcnt[1];
        lines_in = 8'h00;
        cyc(8);
        lines_in = 8'h02;
        cyc(24);
        rdc("glitch_state", BASE + 5'd3, 8'h02);
        check("glitch_no_pulse", 8'(pcnt[1] - p1), 8'd0);
        lines_in = 8'h00;
        cyc(28);
        rdc("deb_state_lo", BASE + 5'd3, 8'h00);
        check("deb_one_pulse", 8'(pcnt[1] - p1), 8'd1);

        // Simultaneous rises with RISE=05
        wr(5'd2, 8'h00); wr(5'd0, 8'h05); wr(5'd1, 8'h00);
        p0 = pcnt[0]; p1 = pcnt[1]; p2 = pcnt[2]; p3 = pcnt[3];
        lines_in = 8'h0F;
        cyc(8);
        check("sim_l0", 8'(pcnt[0] - p0), 8'd1);
        check("sim_l1", 8'(pcnt[1] - p1), 8'd0);
        check("sim_l2", 8'(pcnt[2] - p2), 8'd1);
        check("sim_l3", 8'(pcnt[3] - p3), 8'd0);

        // CSR write behaviour: DEB rewrite mid-count, STATE read-only, hole address
        wr(5'd2, 8'h03); wr(5'd1, 8'hFF);
        lines_in = 8'h1F;
        cyc(6);
        wr(5'd2, 8'hF7);
        rdc("deb_mask", BASE + 5'd2, 8'h07);
        cyc(40);
        rdc("deb7_state", BASE + 5'd3, 8'h1F);
        wr(5'd3, 8'hAA);
        rdm("state_ro", BASE + 5'd3);
        rdc("hole", BASE + 5'd4, 8'h00);

        // Reset in the middle of a pulse
        wr(5'd2, 8'h00); wr(5'd0, 8'h01);
        lines_in = 8'h1E;
        cyc(5);
        lines_in = 8'h1F;
        repeat (3) @(posedge clk);
        #2 check("pulse_pre_reset", irqs_out, 8'h01);
        async_reset("reset_mid_pulse");
        release_en();
        cyc(6);

        // Reset while line2 is mid-debounce; no pulse after release
        wr(5'd2, 8'h03);
        p2 = pcnt[2];
        lines_in = 8'h1B;
        cyc(7);
        @(posedge clk);
        async_reset("reset_mid_deb");
        release_en();
        cyc(20);
        check("no_pulse_after_rst", 8'(pcnt[2] - p2), 8'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 150; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            case (r)
                0: wr(5'd2, {4'($urandom), 4'($urandom_range(0, 3))});
                1: wr(5'd0, 8'($urandom));
                2: wr(5'd1, 8'($urandom));
                3: rdm("rand_state", BASE + 5'd3);
                default: begin
                    lines_in = lines_in ^ 8'($urandom);
                    cyc(int'($urandom_range(1, 14)));
                end
            endcase
        end
        cyc(6);
        check("sb_drained", 8'(sb.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
